// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Receiving end of the program-memory load path plus the fetch front end.
// A loader writes instructions into on-chip program memory; on `run` the unit
// reads memory back sequentially from address 0 into a two-entry prefetch
// buffer and hands instructions to the decoder over a valid/ready handshake.
// Jumps redirect fetch; delivering HALT_OP stops fetching.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   asynchronous, active-high reset
//   pmWrEn         in   program-memory write enable (ignored while fetching)
//   pm_addr        in   write address
//   instructionIn  in   write data
//   run            in   start fetching from address 0
//   jump_en        in   redirect fetch to jump_addr (FETCH state only)
//   jump_addr      in   jump target
//   instr_out      out  instruction at buffer head
//   pc_out         out  address of instr_out
//   instr_valid    out  buffer head valid
//   instr_ready    in   decoder accepts head
//   busy           out  state is FETCH
//   halted         out  state is HALT
//   wr_err         out  (only with IFU_WR_ERR_EN) one-cycle pulse after a
//                       write attempt was dropped because the unit was fetching
//
// Build option: define IFU_WR_ERR_EN to add the wr_err output.
// ============================================================================
module instr_fetch_unit #(
    parameter int                    ADD_WIDTH  = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_OP    = DATA_WIDTH'(8'hFF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmWrEn,
    input  logic [ADD_WIDTH-1:0]  pm_addr,
    input  logic [DATA_WIDTH-1:0] instructionIn,
    input  logic                  run,
    input  logic                  jump_en,
    input  logic [ADD_WIDTH-1:0]  jump_addr,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADD_WIDTH-1:0]  pc_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy,
    output logic                  halted
`ifdef IFU_WR_ERR_EN
    ,
    output logic                  wr_err
`endif
);

    localparam int DEPTH = 2 ** ADD_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_HALT
    } state_e;

    // Program memory.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADD_WIDTH-1:0]  pc_q, pc_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [ADD_WIDTH-1:0]  head_pc_q, head_pc_d;
    logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
    logic [ADD_WIDTH-1:0]  tail_pc_q, tail_pc_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  wr_err_q, wr_err_d;

    logic                  in_fetch;
    logic                  mem_we;
    logic                  pop;
    logic                  halt_pop;
    logic                  run_accept;
    logic                  jump;
    logic                  push;
    logic                  flush;
    logic [DATA_WIDTH-1:0] fetch_data;

    assign fetch_data = mem[pc_q];

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    always_comb begin
        in_fetch   = (state_q == S_FETCH);
        mem_we     = pmWrEn && !in_fetch;
        pop        = (cnt_q != 2'd0) && instr_ready;
        // Halt wins over a same-cycle jump.
        halt_pop   = pop && (head_data_q == HALT_OP);
        // A same-cycle write beats run.
        run_accept = !in_fetch && run && !pmWrEn;
        jump       = in_fetch && jump_en && !halt_pop;
        // Fill while there is room, or when the full buffer is draining this
        // cycle; a redirect or halt discards the word read at the old pc.
        push       = in_fetch && !halt_pop && !jump &&
                     ((cnt_q != 2'd2) || pop);
        flush      = halt_pop || jump || run_accept;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        tail_data_d = tail_data_q;
        tail_pc_d   = tail_pc_q;
        wr_err_d    = in_fetch && pmWrEn;

        unique case (state_q)
            S_IDLE, S_LOAD, S_HALT: begin
                if (pmWrEn) begin
                    state_d = S_LOAD;
                end else if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (halt_pop) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (run_accept) begin
            pc_d = '0;
        end else if (jump) begin
            pc_d = jump_addr;
        end else if (push) begin
            pc_d = pc_q + ADD_WIDTH'(1);  // wraps naturally at DEPTH-1
        end

        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        head_data_d = tail_data_q;
                        head_pc_d   = tail_pc_q;
                        tail_data_d = fetch_data;
                        tail_pc_d   = pc_q;
                    end else begin
                        head_data_d = fetch_data;
                        head_pc_d   = pc_q;
                    end
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_pc_d   = tail_pc_q;
                    cnt_d       = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_data_d = fetch_data;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_data_d = fetch_data;
                        tail_pc_d   = pc_q;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end

        busy_d   = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            cnt_q       <= 2'd0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            tail_data_q <= '0;
            tail_pc_q   <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
            tail_data_q <= tail_data_d;
            tail_pc_q   <= tail_pc_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // NOTE: program memory has no reset so a loaded program survives rst and
    // the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[pm_addr] <= instructionIn;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instr_out   = head_data_q;
    assign pc_out      = head_pc_q;
    assign instr_valid = (cnt_q != 2'd0);
    assign busy        = busy_q;
    assign halted      = halted_q;

`ifdef IFU_WR_ERR_EN
    assign wr_err = wr_err_q;
`else
    logic unused_wr_err;
    assign unused_wr_err = wr_err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Directed bench for instr_fetch_unit. A reference copy of program memory
// supplies expected {instruction, pc} pairs that are queued when a run is
// started and compared whenever the DUT completes a handshake.
// ============================================================================
module tb_instr_fetch_unit;

    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pmWrEn;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] instructionIn;
    logic          run;
    logic          jump_en;
    logic [AW-1:0] jump_addr;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] pc_out;
    logic          instr_valid;
    logic          instr_ready;
    logic          busy;
    logic          halted;
`ifdef IFU_WR_ERR_EN
    logic          wr_err;
`endif

    logic [DW-1:0] tb_mem [2**AW];
    exp_t          sb_q [$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADD_WIDTH (AW),
        .DATA_WIDTH(DW),
        .HALT_OP   (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmWrEn       (pmWrEn),
        .pm_addr      (pm_addr),
        .instructionIn(instructionIn),
        .run          (run),
        .jump_en      (jump_en),
        .jump_addr    (jump_addr),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .busy         (busy),
        .halted       (halted)
`ifdef IFU_WR_ERR_EN
        ,
        .wr_err       (wr_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already set: score any handshake that
    // completes at the coming posedge, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        if (instr_valid && instr_ready) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("instr_out", 32'(instr_out), 32'(e.data));
                check("pc_out", 32'(pc_out), 32'(e.pc));
            end
        end
        @(negedge clk);
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pmWrEn = 1'b1; pm_addr = a; instructionIn = d;
        tick();
        pmWrEn = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic expect_from(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{data: tb_mem[a], pc: a});
            a = a + AW'(1);
        end
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Pop with ready held high until halted; bounded by a cycle budget.
    task automatic drain(input int budget, input int exp_cycles);
        int n;
        n = 0;
        instr_ready = 1'b1;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check("cycles_to_halt", 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        rst = 1'b1; pmWrEn = 1'b0; pm_addr = '0; instructionIn = '0;
        run = 1'b0; jump_en = 1'b0; jump_addr = '0; instr_ready = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- load then run ----
        write_mem(0, 8'h11); write_mem(1, 8'h22);
        write_mem(2, 8'h33); write_mem(3, 8'hFF);
        expect_from(0, 4);
        instr_ready = 1'b1;
        start_run();
        check("run_busy", 32'(busy), 32'd1);
        check("run_valid_e0", 32'(instr_valid), 32'd0);
        tick();
        check("run_valid_e1", 32'(instr_valid), 32'd1);
        drain(20, 4);
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_valid", 32'(instr_valid), 32'd0);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- backpressure ----
        instr_ready = 1'b0;
        expect_from(0, 4);
        start_run();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_head", 32'(instr_out), 32'h11);
            check("bp_pc", 32'(pc_out), 32'd0);
        end
        drain(20, 4);
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- jump ----
        write_mem(0, 8'h01); write_mem(1, 8'h02);
        write_mem(2, 8'h03); write_mem(3, 8'h04);
        write_mem(9, 8'h09); write_mem(10, 8'hFF);
        instr_ready = 1'b0;
        expect_from(0, 1);
        expect_from(9, 2);
        start_run();
        tick();
        instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 4'd9;
        tick();
        jump_en = 1'b0;
        check("jmp_valid_gap", 32'(instr_valid), 32'd0);
        drain(20, 3);
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- write beats run in the same cycle ----
        instr_ready = 1'b0;
        pmWrEn = 1'b1; pm_addr = 4'd0; instructionIn = 8'h40; run = 1'b1;
        tick();
        pmWrEn = 1'b0; run = 1'b0; tb_mem[0] = 8'h40;
        check("wr_run_busy", 32'(busy), 32'd0);
        check("wr_run_halted", 32'(halted), 32'd0);

        // ---- wrap (no HALT_OP anywhere) ----
        for (int i = 0; i < 16; i++) write_mem(AW'(i), DW'(8'h40 + i));
        expect_from(0, 20);
        instr_ready = 1'b1;
        start_run();
        tick();
        for (int i = 0; i < 20; i++) tick();
        instr_ready = 1'b0;
        check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- write during fetch is dropped ----
        pmWrEn = 1'b1; pm_addr = 4'd2; instructionIn = 8'hAA;
        tick();
        pmWrEn = 1'b0;
        check("wf_busy", 32'(busy), 32'd1);
`ifdef IFU_WR_ERR_EN
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_clear", 32'(wr_err), 32'd0);
`endif

        // ---- async reset mid-fetch ----
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pc", 32'(pc_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_from(0, 6);
        start_run();
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        instr_ready = 1'b0;
        check("rerun_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
